branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter TABLE_DEPTH, default 16, meaning number of 2-bit counter entries; power of two, 2 to 256.
REQ-002 SHALL have parameter INIT_STATE, default 2'b10 (weakly taken), meaning the counter value loaded into every entry at reset.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port lookup_valid_i, input, 1 bit: the instruction in ID is a branch.
REQ-006 SHALL have port lookup_pc_i, input, 32 bits: PC of the ID-stage instruction.
REQ-007 SHALL have port predict_o, output, 1 bit: predicted taken; this feeds the flush decider's prediction input and the IF PC select.
REQ-008 SHALL have port update_valid_i, input, 1 bit: a branch resolves in EX this cycle.
REQ-009 SHALL have port update_pc_i, input, 32 bits: PC of the resolving branch.
REQ-010 SHALL have port update_taken_i, input, 1 bit: actual outcome, 1 meaning taken.
REQ-011 SHALL have port update_predicted_i, input, 1 bit: the prediction carried down the pipeline with the resolving branch.
REQ-012 SHALL have ports hit_cnt_o and miss_cnt_o, output, 32 bits each, present only when BRANCH_PREDICTOR_STATS_EN is defined.

Function
REQ-013 SHALL index the table with pc[IDX_W+1:2], where IDX_W = log2(TABLE_DEPTH); the same rule applies to lookup and update.
REQ-014 SHALL keep each entry as a 2-bit saturating FSM with states 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
REQ-015 SHALL, on a clock edge with update_valid_i=1 and update_taken_i=1, increment the indexed entry, saturating at 11.
REQ-016 SHALL, on a clock edge with update_valid_i=1 and update_taken_i=0, decrement the indexed entry, saturating at 00.
REQ-017 SHALL leave every entry unchanged when update_valid_i=0.
REQ-018 SHALL drive predict_o combinationally as lookup_valid_i AND bit[1] of the indexed entry, with zero-cycle latency; predict_o=0 when lookup_valid_i=0.
REQ-019 SHALL, when lookup and update hit the same index in the same cycle, drive predict_o from the pre-update value (no bypass); the new value is visible from the next cycle.
REQ-020 SHALL treat aliasing PCs (same index bits) as sharing one entry; no tag check.
REQ-021 SHALL ignore update_predicted_i for table state; it is used only for statistics.

Reset
REQ-022 SHALL, while rst_i=1, asynchronously set every entry to INIT_STATE, and set predict_o to lookup_valid_i AND INIT_STATE[1].
REQ-023 SHALL, when rst_i is asserted during an update cycle, discard that update, with reset winning.
REQ-024 SHALL clear hit_cnt_o and miss_cnt_o to 0 on reset.

Configuration
REQ-025 SHALL, with BRANCH_PREDICTOR_STATS_EN defined, increment hit_cnt_o on each update where update_predicted_i==update_taken_i, else increment miss_cnt_o; both counters wrap modulo 2^32.
REQ-026 SHALL, without BRANCH_PREDICTOR_STATS_EN, omit both counter ports and their logic; table behaviour is identical in both builds.

Structure
REQ-027 SHALL place the four counter-state encodings (typedef) and the default INIT_STATE constant in shared package bp_pkg.
REQ-028 SHALL implement the per-entry next-state function as sub-module sat_counter2, taking the current state and taken flag and returning the next state; instantiate it once on the update path.

Verification
REQ-029 SHALL check reset: with rst_i pulsed, lookup_valid_i=1 and any PC -> predict_o=1 (INIT_STATE=10); with STATS_EN, hit_cnt_o=0 and miss_cnt_o=0.
REQ-030 SHALL check saturation: four not-taken updates at PC 0x40 -> entry 00 and predict_o=0; then two taken updates -> entry 10 and predict_o=1.
REQ-031 SHALL check upper saturation: five taken updates at PC 0x44 -> entry stays 11; one not-taken -> 10 and predict_o still 1.
REQ-032 SHALL check the same-cycle conflict: entry at 0x48 is 10, with lookup and a not-taken update both at 0x48 -> predict_o=1 that cycle and 0 the next.
REQ-033 SHALL check aliasing: with TABLE_DEPTH=16, not-taken updates at 0x08 and 0x48 -> both PCs read entry index 2 with the same prediction.
REQ-034 SHALL check statistics and mid-update reset: three hits then one miss -> hit_cnt_o=3 and miss_cnt_o=1; rst_i asserted during the next update -> counters 0 and entry at INIT_STATE.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the 2-bit saturating-counter branch predictor.
package bp_pkg;

    typedef enum logic [1:0] {
        BP_STRONG_NT = 2'b00,
        BP_WEAK_NT   = 2'b01,
        BP_WEAK_T    = 2'b10,
        BP_STRONG_T  = 2'b11
    } bp_state_e;

    localparam logic [1:0] BP_INIT_STATE = 2'b10;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of one 2-bit saturating branch counter.
module sat_counter2
    import bp_pkg::*;
(
    input  bp_state_e cur_state,
    input  logic      taken,
    output bp_state_e next_state
);

    // Saturating increment on taken, saturating decrement otherwise
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            BP_STRONG_NT: next_state = taken ? BP_WEAK_NT  : BP_STRONG_NT;
            BP_WEAK_NT:   next_state = taken ? BP_WEAK_T   : BP_STRONG_NT;
            BP_WEAK_T:    next_state = taken ? BP_STRONG_T : BP_WEAK_NT;
            BP_STRONG_T:  next_state = taken ? BP_STRONG_T : BP_WEAK_T;
            default:      next_state = cur_state;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of 2-bit counters indexed by pc[IDX_W+1:2].
// Define BRANCH_PREDICTOR_STATS_EN to add hit/miss counters (hit_cnt_o, miss_cnt_o).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         TABLE_DEPTH = 16,
    parameter logic [1:0] INIT_STATE  = BP_INIT_STATE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lookup_valid_i,
    input  logic [31:0] lookup_pc_i,
    output logic        predict_o,
    input  logic        update_valid_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic        update_predicted_i
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    localparam int IDX_W = $clog2(TABLE_DEPTH);

    bp_state_e        table_r [TABLE_DEPTH];
    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] update_idx_s;
    bp_state_e        update_cur_s;
    bp_state_e        update_next_s;
    logic             predict_s;

    assign lookup_idx_s = lookup_pc_i[IDX_W+1:2];
    assign update_idx_s = update_pc_i[IDX_W+1:2];
    assign update_cur_s = table_r[update_idx_s];

    sat_counter2 u_sat_counter2 (
        .cur_state  (update_cur_s),
        .taken      (update_taken_i),
        .next_state (update_next_s)
    );

    // Table state; reset overrides any update presented in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                table_r[i] <= bp_state_e'(INIT_STATE);
            end
        end else if (update_valid_i) begin
            table_r[update_idx_s] <= update_next_s;
        end
    end

    // Prediction reads the stored value only, so a same-cycle update is not bypassed
    always_comb begin
        predict_s = 1'b0;
        if (lookup_valid_i) begin
            predict_s = table_r[lookup_idx_s][1];
        end else begin
            predict_s = 1'b0;
        end
    end

    assign predict_o = predict_s;

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] hit_cnt_r;
    logic [31:0] miss_cnt_r;

    // Resolution statistics, wrapping naturally at 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (update_valid_i) begin
            if (update_predicted_i == update_taken_i) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end else begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_r;
    assign miss_cnt_o = miss_cnt_r;

    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0],
                                update_pc_i[31:IDX_W+2], update_pc_i[1:0]};
`else
    // Outside the statistics build the carried prediction has no consumer
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0],
                                update_pc_i[31:IDX_W+2], update_pc_i[1:0],
                                update_predicted_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic
// compared against an array-of-integers counter model.
module tb_branch_predictor;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        lookup_valid_i = 1'b0;
    logic [31:0] lookup_pc_i = 32'd0;
    logic        predict_o;
    logic        update_valid_i = 1'b0;
    logic [31:0] update_pc_i = 32'd0;
    logic        update_taken_i = 1'b0;
    logic        update_predicted_i = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          model_ctr [DEPTH];
    logic [31:0] exp_hit = 32'd0;
    logic [31:0] exp_miss = 32'd0;

    always #5 clk = ~clk;

    branch_predictor #(.TABLE_DEPTH(DEPTH), .INIT_STATE(2'b10)) dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .lookup_valid_i     (lookup_valid_i),
        .lookup_pc_i        (lookup_pc_i),
        .predict_o          (predict_o),
        .update_valid_i     (update_valid_i),
        .update_pc_i        (update_pc_i),
        .update_taken_i     (update_taken_i),
        .update_predicted_i (update_predicted_i)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .hit_cnt_o          (hit_cnt_o),
        .miss_cnt_o         (miss_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    function automatic logic model_predict(input logic lv, input logic [31:0] pc);
        return lv && (model_ctr[idx_of(pc)] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_ctr[i] = 2;
        exp_hit = 32'd0;
        exp_miss = 32'd0;
    endtask

    // One cycle: drive, check prediction against the pre-update model, then advance model
    task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic ut, input logic up, input string tag);
        int k;
        @(negedge clk);
        lookup_valid_i = lv;  lookup_pc_i = lpc;
        update_valid_i = uv;  update_pc_i = upc;
        update_taken_i = ut;  update_predicted_i = up;
        #1;
        check(tag, {31'd0, predict_o}, {31'd0, model_predict(lv, lpc)});
        @(posedge clk);
        if (uv) begin
            k = idx_of(upc);
            if (ut) model_ctr[k] = (model_ctr[k] < 3) ? model_ctr[k] + 1 : 3;
            else    model_ctr[k] = (model_ctr[k] > 0) ? model_ctr[k] - 1 : 0;
            if (up == ut) exp_hit = exp_hit + 32'd1;
            else          exp_miss = exp_miss + 32'd1;
        end
    endtask

    // Lookup-only cycle compared against an explicit expected value
    task automatic probe(input logic [31:0] pc, input logic exp, input string tag);
        @(negedge clk);
        lookup_valid_i = 1'b1; lookup_pc_i = pc; update_valid_i = 1'b0;
        #1;
        check(tag, {31'd0, predict_o}, {31'd0, exp});
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        update_valid_i = 1'b0;
        rst_i = 1'b1;
        lookup_valid_i = 1'b1; lookup_pc_i = 32'h0000_1234;
        #1;
        check("rst_predict", {31'd0, predict_o}, 32'd1);
        lookup_valid_i = 1'b0;
        #1;
        check("rst_predict_novalid", {31'd0, predict_o}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_i = 1'b0;
`ifdef BRANCH_PREDICTOR_STATS_EN
        #1;
        check("rst_hit_cnt", hit_cnt_o, 32'd0);
        check("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        model_reset();
        pulse_reset();

        // Lower saturation at 0x40
        for (int i = 0; i < 4; i++) step(1'b1, 32'h40, 1'b1, 32'h40, 1'b0, 1'b1, "sat_lo_seq");
        probe(32'h40, 1'b0, "sat_lo_predict");
        step(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, "sat_lo_t1");
        probe(32'h40, 1'b0, "sat_lo_one_taken");
        step(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, "sat_lo_t2");
        probe(32'h40, 1'b1, "sat_lo_two_taken");

        // Upper saturation at 0x44
        for (int i = 0; i < 5; i++) step(1'b1, 32'h44, 1'b1, 32'h44, 1'b1, 1'b1, "sat_hi_seq");
        step(1'b0, 32'h0, 1'b1, 32'h44, 1'b0, 1'b1, "sat_hi_nt1");
        probe(32'h44, 1'b1, "sat_hi_one_nt");
        step(1'b0, 32'h0, 1'b1, 32'h44, 1'b0, 1'b1, "sat_hi_nt2");
        probe(32'h44, 1'b0, "sat_hi_two_nt");

        // Same-cycle lookup/update at 0x48 (entry still at weakly taken)
        @(negedge clk);
        lookup_valid_i = 1'b1; lookup_pc_i = 32'h48;
        update_valid_i = 1'b1; update_pc_i = 32'h48; update_taken_i = 1'b0; update_predicted_i = 1'b1;
        #1;
        check("conflict_same_cycle", {31'd0, predict_o}, 32'd1);
        @(posedge clk);
        model_ctr[idx_of(32'h48)] = 1;
        exp_miss = exp_miss + 32'd1;
        probe(32'h48, 1'b0, "conflict_next_cycle");

        // Aliasing: 0x08 and 0x48 share index 2
        pulse_reset();
        step(1'b0, 32'h0, 1'b1, 32'h08, 1'b0, 1'b0, "alias_nt08");
        step(1'b0, 32'h0, 1'b1, 32'h48, 1'b0, 1'b0, "alias_nt48");
        probe(32'h08, 1'b0, "alias_08_after_nt");
        probe(32'h48, 1'b0, "alias_48_after_nt");
        step(1'b0, 32'h0, 1'b1, 32'h08, 1'b1, 1'b0, "alias_t08");
        probe(32'h48, 1'b0, "alias_48_weak_nt");
        step(1'b0, 32'h0, 1'b1, 32'h48, 1'b1, 1'b0, "alias_t48");
        probe(32'h08, 1'b1, "alias_08_shared");

        // Statistics then reset in the middle of an update
        pulse_reset();
        step(1'b0, 32'h0, 1'b1, 32'h4C, 1'b1, 1'b1, "stat_hit1");
        step(1'b0, 32'h0, 1'b1, 32'h4C, 1'b0, 1'b0, "stat_hit2");
        step(1'b0, 32'h0, 1'b1, 32'h4C, 1'b1, 1'b1, "stat_hit3");
        step(1'b0, 32'h0, 1'b1, 32'h4C, 1'b1, 1'b0, "stat_miss1");
        probe(32'h4C, 1'b1, "stat_entry_taken");
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("stat_hit_cnt", hit_cnt_o, 32'd3);
        check("stat_miss_cnt", miss_cnt_o, 32'd1);
`endif
        @(negedge clk);
        lookup_valid_i = 1'b0;
        update_valid_i = 1'b1; update_pc_i = 32'h4C; update_taken_i = 1'b0; update_predicted_i = 1'b1;
        rst_i = 1'b1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_i = 1'b0; update_valid_i = 1'b0;
        // 0x4C reached strongly taken before reset; INIT shows as weakly taken
        step(1'b0, 32'h0, 1'b1, 32'h4C, 1'b0, 1'b0, "midrst_nt");
        probe(32'h4C, 1'b0, "midrst_entry_init");
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("midrst_hit_cnt", hit_cnt_o, 32'd1);
        check("midrst_miss_cnt", miss_cnt_o, 32'd0);
`endif

        // Random traffic against the model
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] lpc;
            logic [31:0] upc;
            lpc = $urandom;
            upc = $urandom;
            if ($urandom_range(0, 1) == 0) upc = lpc;
            step(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 1)), upc,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand_predict");
        end
        for (int i = 0; i < DEPTH; i++) begin
            probe(32'(i * 4), model_ctr[i] >= 2, "rand_final_entry");
        end
`ifdef BRANCH_PREDICTOR_STATS_EN
        check("rand_hit_cnt", hit_cnt_o, exp_hit);
        check("rand_miss_cnt", miss_cnt_o, exp_miss);
`endif

        @(negedge clk);
        lookup_valid_i = 1'b0; update_valid_i = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
